demux_1x4_reg: RTL and testbench
================================

# demux_1x4_reg

Registered 1-to-4 demultiplexer: the inverse of the 4:1 select mux in the ALU datapath. A single input word carries valid/ready flow control and is steered by `{sel1, sel0}` into one of four output channels. Each channel holds the word in its own one-entry register until the consumer accepts it. It sits on the ALU result path and routes one result word to one of four destinations: register file write port, flags unit, shifter feedback, or debug tap.

## Interface
Parameters:
- `WIDTH`, default 8: data width of the input and of each output channel.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_data`, input, WIDTH: word to route.
- `in_valid`, input, 1: `in_data` and the select bits are valid.
- `in_ready`, output, 1: the block accepts the word this cycle.
- `sel0`, input, 1: select bit 0 (LSB of channel index).
- `sel1`, input, 1: select bit 1 (MSB of channel index).
- `out0`..`out3`, output, WIDTH each: channel data, driven from the holding registers.
- `out_valid0`..`out_valid3`, output, 1 each: channel holds a word.
- `out_ready0`..`out_ready3`, input, 1 each: consumer of that channel takes the word this cycle.

## Operation
- Channel index is k = {sel1, sel0}. Mapping: 00 selects ch0, 01 ch1, 10 ch2, 11 ch3. This is identical to the mux mapping: c0 at !s1·!s0, c1 at !s1·s0, c2 at s1·!s0, c3 at s1·s0.
- Each channel i has a data register d_i (WIDTH bits) and a valid flag v_i. `out<i>` = d_i and `out_valid<i>` = v_i, both direct register outputs with no combinational path from the inputs.
- `in_ready` = !v_k | `out_ready<k>`. It is combinational from `sel0`, `sel1`, v_k and `out_ready<k>`, and does not depend on `in_valid`.
- Accept: `in_valid` & `in_ready` on an edge loads d_k ← `in_data` and sets v_k ← 1.
- Drain: v_i & `out_ready<i>` on an edge clears v_i, unless channel i is loaded on the same edge, in which case v_i stays 1 and d_i takes the new word.
- Non-selected channels are never written; their d_i holds while v_i = 0 and while v_i = 1.
- All four channels drain independently. Up to four drains plus one load can occur on the same edge.
- The select bits are sampled only on the accepting edge. The source may change `sel0`/`sel1` while `in_valid` is high and `in_ready` is low; `in_ready` re-evaluates against the newly selected channel. The source must hold `in_data` until it is accepted.
- `out_ready<i>` while v_i = 0 has no effect.
- Per-channel state machine:
  - EMPTY (v=0) → FULL on load.
  - FULL (v=1) → EMPTY on drain without load.
  - FULL → FULL on drain with load (d replaced), and also with no drain (load blocked by `in_ready` = 0).

## Timing
- Reset (`rst_n` low, asynchronous): all v_i ← 0 and all d_i ← 0 immediately, without waiting for a clock.
  - All `out_valid<i>` = 0 and all `out<i>` = 0 while reset is held.
  - `in_ready` = 1 while in reset (every v = 0), but no accept occurs until `rst_n` is high at a rising edge.
- Reset deassertion is synchronous to `clk` by the system; the first accept can occur on the first rising edge with `rst_n` = 1.
- Reset mid-operation: any held words are discarded, with no partial transfer and no glitch back to valid.
- Latency: a word accepted at edge N appears on `out<k>` with `out_valid<k>` = 1 after edge N. The earliest consumer take is at edge N+1.
- Throughput, same channel with its ready held high: one word per cycle.
- Throughput, alternating channels: one word per cycle regardless of output readiness, until the target channel is full.
- Backpressure: a full channel with its ready low stalls only inputs that select that channel. Inputs that select other channels proceed.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-cycle with ch2 holding 0x5A → `out_valid2` falls before the next edge. All `out<i>` = 0x00. `in_ready` = 1.
- **Routing:** send 0x11, 0x22, 0x33, 0x44 with sel = 00, 01, 10, 11 on four consecutive cycles, all readies low → `out0`..`out3` = 0x11/0x22/0x33/0x44, all valid. A fifth word with sel = 01 sees `in_ready` = 0.
- **Stall and redirect:** ch1 full with `out_ready1` = 0, input 0x77 sel = 01 → `in_ready` = 0 and ch1 keeps 0x22. Change sel to 11 with ch3 empty → 0x77 lands in ch3 on the next edge.
- **Simultaneous drain and load:** ch0 holds 0xA0, `out_ready0` = 1, input 0xB0 sel = 00 valid on the same edge → consumer takes 0xA0. `out0` = 0xB0 with `out_valid0` staying 1. No bubble.
- **Streaming:** `out_ready2` held at 1, 16 words 0x00..0x0F with sel = 10 back-to-back → `in_ready` constantly 1. Ch2 outputs 0x00..0x0F, one per cycle, in order. Other channels are untouched.
- **Parallel drain:** all four channels full, all readies pulsed high for one cycle with no input → all four `out_valid` clear on that edge. Data registers keep their last values.

Source files
------------

// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready flow control.
// Each output channel owns a one-entry holding register.
module demux_1x4_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel0,
  input  logic             sel1,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic             out_valid3,
  input  logic             out_ready0,
  input  logic             out_ready1,
  input  logic             out_ready2,
  input  logic             out_ready3
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [3:0]       outReady;
  logic [1:0]       selIdx;
  logic             loadEn;

  assign selIdx   = {sel1, sel0};
  assign outReady = {out_ready3, out_ready2, out_ready1, out_ready0};

  // A full channel can still accept if its consumer drains on the same edge.
  assign in_ready = (valid_q[selIdx] == EMPTY) | outReady[selIdx];
  assign loadEn   = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q & ~outReady;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = data_q[i];
    end
    if (loadEn) begin
      valid_d[selIdx] = FULL;
      data_d[selIdx]  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out0       = data_q[0];
  assign out1       = data_q[1];
  assign out2       = data_q[2];
  assign out3       = data_q[3];
  assign out_valid0 = valid_q[0];
  assign out_valid1 = valid_q[1];
  assign out_valid2 = valid_q[2];
  assign out_valid3 = valid_q[3];

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Testbench for demux_1x4_reg: vector table, per-channel scoreboard
// and hand-written reset, streaming and parallel-drain sequences.
module tb_demux_1x4_reg;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       sel0, sel1;
  logic [7:0] out0, out1, out2, out3;
  logic       out_valid0, out_valid1, out_valid2, out_valid3;
  logic       out_ready0, out_ready1, out_ready2, out_ready3;

  demux_1x4_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel0(sel0), .sel1(sel1),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_valid2(out_valid2), .out_valid3(out_valid3),
    .out_ready0(out_ready0), .out_ready1(out_ready1),
    .out_ready2(out_ready2), .out_ready3(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] dutOut [4];
  logic [3:0] dutValid;
  assign dutOut[0] = out0;
  assign dutOut[1] = out1;
  assign dutOut[2] = out2;
  assign dutOut[3] = out3;
  assign dutValid  = {out_valid3, out_valid2, out_valid1, out_valid0};

  int checks = 0;
  int errors = 0;

  // Reference state and per-channel queues of words awaiting drain.
  logic [3:0] mV;
  logic [7:0] mD [4];
  logic [7:0] sbQ [4][$];

  typedef struct {
    logic       vld;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] rdy;
    logic       expReady;
    logic [3:0] expValid;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput($sformatf("%s valid", tag), {28'd0, dutValid}, {28'd0, mV});
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s out%0d", tag, i), {24'd0, dutOut[i]}, {24'd0, mD[i]});
    end
  endtask

  task automatic sbPop(input int ch);
    logic [7:0] exp;
    checks++;
    if (sbQ[ch].size() == 0) begin
      errors++;
      $display("[TB] FAIL drain ch%0d: got 0x%0h, expected no pending word", ch, dutOut[ch]);
    end else begin
      exp = sbQ[ch].pop_front();
      if (dutOut[ch] !== exp || dutValid[ch] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL drain ch%0d: got 0x%0h valid %0b, expected 0x%0h valid 1",
                 ch, dutOut[ch], dutValid[ch], exp);
      end
    end
  endtask

  task automatic resetModel();
    mV = '0;
    for (int i = 0; i < 4; i++) begin
      mD[i] = 8'h00;
      sbQ[i].delete();
    end
  endtask

  // One clock cycle: drive, check handshake and drains before the edge, update model, check after.
  task automatic applyStimulus(input logic vld, input logic [1:0] sel, input logic [7:0] data,
                               input logic [3:0] rdy, input string tag, output logic seenReady);
    logic expReady;
    in_valid = vld;
    {sel1, sel0} = sel;
    in_data = data;
    {out_ready3, out_ready2, out_ready1, out_ready0} = rdy;
    @(negedge clk);
    seenReady = in_ready;
    expReady = ~mV[sel] | rdy[sel];
    checkOutput($sformatf("%s in_ready", tag), {31'd0, in_ready}, {31'd0, expReady});
    for (int i = 0; i < 4; i++) begin
      if (mV[i] && rdy[i]) sbPop(i);
    end
    mV = mV & ~rdy;
    if (vld && expReady) begin
      mV[sel] = 1'b1;
      mD[sel] = data;
      sbQ[sel].push_back(data);
    end
    @(posedge clk);
    #1;
    checkModel(tag);
  endtask

  initial begin
    logic r;

    vecs[0]  = '{1'b1, 2'd0, 8'h11, 4'b0000, 1'b1, 4'b0001, 8'h11};
    vecs[1]  = '{1'b1, 2'd1, 8'h22, 4'b0000, 1'b1, 4'b0011, 8'h22};
    vecs[2]  = '{1'b1, 2'd2, 8'h33, 4'b0000, 1'b1, 4'b0111, 8'h33};
    vecs[3]  = '{1'b1, 2'd3, 8'h44, 4'b0000, 1'b1, 4'b1111, 8'h44};
    vecs[4]  = '{1'b1, 2'd1, 8'h55, 4'b0000, 1'b0, 4'b1111, 8'h22};
    vecs[5]  = '{1'b1, 2'd1, 8'h77, 4'b0000, 1'b0, 4'b1111, 8'h22};
    vecs[6]  = '{1'b0, 2'd3, 8'h77, 4'b1000, 1'b1, 4'b0111, 8'h44};
    vecs[7]  = '{1'b1, 2'd1, 8'h77, 4'b0000, 1'b0, 4'b0111, 8'h22};
    vecs[8]  = '{1'b1, 2'd3, 8'h77, 4'b0000, 1'b1, 4'b1111, 8'h77};
    vecs[9]  = '{1'b1, 2'd0, 8'hA0, 4'b0001, 1'b1, 4'b1111, 8'hA0};
    vecs[10] = '{1'b1, 2'd0, 8'hB0, 4'b0001, 1'b1, 4'b1111, 8'hB0};
    vecs[11] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 4'b1111, 8'hB0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    {sel1, sel0} = 2'b00;
    {out_ready3, out_ready2, out_ready1, out_ready0} = 4'b0000;
    resetModel();
    #12;
    checkModel("reset");
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] vector table: routing, stall/redirect, drain+load");
    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].vld, vecs[v].sel, vecs[v].data, vecs[v].rdy, $sformatf("vec%0d", v), r);
      checkOutput($sformatf("vec%0d table in_ready", v), {31'd0, r}, {31'd0, vecs[v].expReady});
      checkOutput($sformatf("vec%0d table valid", v), {28'd0, dutValid}, {28'd0, vecs[v].expValid});
      checkOutput($sformatf("vec%0d table out", v), {24'd0, dutOut[vecs[v].sel]}, {24'd0, vecs[v].expOut});
    end

    $display("[TB] parallel drain");
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111, "pdrain", r);
    checkOutput("pdrain valid", {28'd0, dutValid}, 32'd0);
    checkOutput("pdrain out0 held", {24'd0, out0}, 32'hB0);
    checkOutput("pdrain out3 held", {24'd0, out3}, 32'h77);

    $display("[TB] streaming on ch2");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 2'd2, 8'(k), 4'b0100, $sformatf("stream%0d", k), r);
      checkOutput($sformatf("stream%0d const in_ready", k), {31'd0, r}, 32'd1);
      checkOutput($sformatf("stream%0d out2", k), {24'd0, out2}, k);
    end
    applyStimulus(1'b0, 2'd2, 8'h00, 4'b0100, "streamtail", r);
    checkOutput("streamtail valid2", {31'd0, out_valid2}, 32'd0);

    $display("[TB] asynchronous reset mid-cycle");
    applyStimulus(1'b1, 2'd2, 8'h5A, 4'b0000, "preload", r);
    checkOutput("preload out2", {24'd0, out2}, 32'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("async valid2", {31'd0, out_valid2}, 32'd0);
    checkModel("async");
    checkOutput("async in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("no accept in reset", {28'd0, dutValid}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd1, 8'hC3, 4'b0000, "postreset", r);
    checkOutput("postreset out1", {24'd0, out1}, 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
